vga_palette_fade: RTL
=====================

// Module: vga_palette_fade
// PURPOSE
//  Downstream stage of the level draw engines. Turns their registered 4-bit color_idx into 24-bit VGA RGB:
//  - looks the index up in a 16-entry writable palette;
//  - applies a frame-stepped global brightness fade (used for level transitions and death);
//  - forces black during blanking, keeping pixel timing aligned with the VGA controller.
// PARAMETERS
//  FADE_MAX         16  full-brightness level; scale = level/FADE_MAX; must be power of two
//  FRAMES_PER_STEP  2   frame_start pulses per one-level fade step (>=1)
// PORTS
//  Clk          in   1   pixel clock
//  Reset        in   1   asynchronous, active-low reset
//  blank_n      in   1   1 = active video; aligned with DrawX/DrawY
//  frame_start  in   1   1-cycle pulse at start of vertical blank
//  color_idx    in   4   palette index from draw engine; arrives 1 cycle after its DrawX/DrawY
//  pal_we       in   1   palette write strobe
//  pal_waddr    in   4   palette entry to write
//  pal_wdata    in   24  {R,G,B} 8 bits each
//  fade_start   in   1   1-cycle request to start a fade
//  fade_dir     in   1   0 = fade out to black, 1 = fade in to full; sampled with fade_start
//  VGA_R        out  8   red output
//  VGA_G        out  8   green output
//  VGA_B        out  8   blue output
//  fade_busy    out  1   high while the FSM is in OUT or IN
//  fade_done    out  1   1-cycle pulse when a fade completes
//  fade_level   out  5   current level, 0..FADE_MAX
// BEHAVIOUR
//  Reset values (async assert, sync release):
//  - VGA_R/G/B = 0, fade_busy = 0, fade_done = 0.
//  - fade_level = FADE_MAX; step counter = 0; FSM = IDLE.
//  - palette[i] = {3{i*17}} (grey ramp).
//  Pipeline:
//  - S0: register blank_n (aligns it with color_idx).
//  - S1: register palette[color_idx] and delayed blank_n.
//  - S2: scale each channel to (c*fade_level)>>log2(FADE_MAX), 13-bit product, truncate to 8 bits;
//    output 0 when delayed blank_n = 0.
//  - RGB appears 3 cycles after its DrawX/blank_n and 2 cycles after color_idx; throughput 1 pixel/clk.
//  - S2 uses fade_level as registered in the same cycle; mid-line level changes are allowed.
//  Palette:
//  - pal_we writes the entry at the clock edge.
//  - A read of the same entry in that cycle returns the old value; the new value is visible next cycle.
//  FSM states: IDLE, OUT, IN.
//  - IDLE + fade_start, target level already reached (dir 0 & level 0, or dir 1 & level FADE_MAX):
//    stay IDLE, pulse fade_done the next cycle.
//  - IDLE + fade_start otherwise: go to OUT (dir 0) or IN (dir 1), clear step counter, fade_busy = 1.
//  - OUT/IN, on each frame_start: step counter +1.
//    When it reaches FRAMES_PER_STEP, clear it and move level by 1 (OUT -1, IN +1).
//  - When the level hits its target (0 or FADE_MAX): return to IDLE, fade_busy = 0, pulse fade_done 1 cycle.
//  - fade_start while busy is ignored; the fade in progress is not altered.
//  - Level never wraps and stays clamped to 0..FADE_MAX.
//  - Reset during a fade aborts it: level = FADE_MAX, IDLE, no fade_done.
//  - frame_start and fade_start in the same cycle while IDLE: start only, no step that cycle.
// CONFIGURATION
//  VGA_FADE_EN defined:
//  - full fade FSM as above.
//  VGA_FADE_EN undefined:
//  - fade_level is tied to FADE_MAX; S2 passes palette colour unscaled, still registered, so latency is unchanged.
//  - fade_busy = 0; fade_start pulses fade_done 1 cycle later, regardless of fade_dir.
// TESTING
//  1. Reset, blank_n = 1, color_idx = 5 -> RGB = {85,85,85} exactly 2 clocks after color_idx; 0 while in reset.
//  2. pal_we addr 3 data 24'hFF8000 while reading idx 3 -> first output is old {51,51,51}; next is FF,80,00.
//  3. fade_start, dir 0, FADE_MAX 16, FRAMES_PER_STEP 2 -> level 15 after 2 frame_starts, 0 after 32;
//     fade_done pulses once; palette 255 at level 8 -> 127.
//  4. From level 0, fade_start dir 1 -> busy; reaches 16 after 32 frames; a fade_start mid-fade has no effect.
//  5. blank_n = 0 with any index -> RGB = 0 three clocks after blank_n falls; resumes 3 clocks after blank_n rises.
//  6. Reset asserted mid-fade at level 7 -> level 16, busy 0, no fade_done.
//     Undefined VGA_FADE_EN: fade_start -> done pulse next cycle, level stays 16.

Source files
------------

// File: rtl/vga_palette_fade_if.sv
// Pixel, palette-write, fade-control and RGB signals between the draw engines,
// the palette/fade stage and the VGA controller.
interface vga_palette_fade_if;
    logic        blank_n;
    logic        frame_start;
    logic [3:0]  color_idx;
    logic        pal_we;
    logic [3:0]  pal_waddr;
    logic [23:0] pal_wdata;
    logic        fade_start;
    logic        fade_dir;
    logic [7:0]  VGA_R;
    logic [7:0]  VGA_G;
    logic [7:0]  VGA_B;
    logic        fade_busy;
    logic        fade_done;
    logic [4:0]  fade_level;

    modport master (
        output blank_n, frame_start, color_idx, pal_we, pal_waddr, pal_wdata,
               fade_start, fade_dir,
        input  VGA_R, VGA_G, VGA_B, fade_busy, fade_done, fade_level
    );

    modport slave (
        input  blank_n, frame_start, color_idx, pal_we, pal_waddr, pal_wdata,
               fade_start, fade_dir,
        output VGA_R, VGA_G, VGA_B, fade_busy, fade_done, fade_level
    );
endinterface

// File: rtl/vga_palette_fade.sv
// Palette lookup, frame-stepped brightness fade and blank forcing for VGA RGB.
// Define VGA_FADE_EN to build the fade FSM; otherwise colours pass at full brightness.
module vga_palette_fade #(
    parameter int FADE_MAX        = 16,
    parameter int FRAMES_PER_STEP = 2
) (
    input  logic             Clk,
    input  logic             Reset,
    vga_palette_fade_if.slave bus
);

    localparam logic [4:0] LVL_MAX = 5'(FADE_MAX);

    logic        blank_d1_r;
    logic        blank_d2_r;
    logic [23:0] pal_r [16];
    logic [23:0] pix_r;
    logic [23:0] rgb_r;
    logic [23:0] rgb_nxt_s;
    logic [4:0]  level_cur_s;
    logic        busy_cur_s;
    logic        done_r;

`ifdef VGA_FADE_EN
    localparam int SHIFT = $clog2(FADE_MAX);
    localparam int SW    = $clog2(FRAMES_PER_STEP + 1);
    localparam logic [SW-1:0] STEP_LAST = SW'(FRAMES_PER_STEP - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OUT  = 2'd1,
        ST_IN   = 2'd2
    } fade_state_t;

    fade_state_t   state_r, state_s;
    logic [SW-1:0] step_r, step_s;
    logic [4:0]    level_r, level_nxt_s;
    logic          done_s;
    logic          busy_r;

    // 8-bit channel times level, divided by the power-of-two full scale
    function automatic logic [7:0] scale_chan(input logic [7:0] c, input logic [4:0] lvl);
        logic [12:0] prod;
        prod = {5'd0, c} * {8'd0, lvl};
        return 8'(prod >> SHIFT);
    endfunction

    // Fade FSM next-state, step counter and level update
    always_comb begin
        state_s     = state_r;
        step_s      = step_r;
        level_nxt_s = level_r;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (bus.fade_start) begin
                    // Target already reached: acknowledge without entering a fade
                    if ((!bus.fade_dir && level_r == 5'd0) || (bus.fade_dir && level_r == LVL_MAX)) begin
                        done_s = 1'b1;
                    end else begin
                        state_s = bus.fade_dir ? ST_IN : ST_OUT;
                        step_s  = SW'(0);
                    end
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_OUT: begin
                if (bus.frame_start) begin
                    if (step_r == STEP_LAST) begin
                        step_s = SW'(0);
                        if (level_r > 5'd1) begin
                            level_nxt_s = level_r - 5'd1;
                        end else begin
                            level_nxt_s = 5'd0;
                            state_s     = ST_IDLE;
                            done_s      = 1'b1;
                        end
                    end else begin
                        step_s = step_r + SW'(1);
                    end
                end else begin
                    state_s = ST_OUT;
                end
            end
            ST_IN: begin
                if (bus.frame_start) begin
                    if (step_r == STEP_LAST) begin
                        step_s = SW'(0);
                        if (level_r < LVL_MAX - 5'd1) begin
                            level_nxt_s = level_r + 5'd1;
                        end else begin
                            level_nxt_s = LVL_MAX;
                            state_s     = ST_IDLE;
                            done_s      = 1'b1;
                        end
                    end else begin
                        step_s = step_r + SW'(1);
                    end
                end else begin
                    state_s = ST_IN;
                end
            end
            default: begin
                state_s     = ST_IDLE;
                step_s      = SW'(0);
                level_nxt_s = LVL_MAX;
            end
        endcase
    end

    // Fade FSM state, level and status registers
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_r <= ST_IDLE;
            step_r  <= SW'(0);
            level_r <= LVL_MAX;
            done_r  <= 1'b0;
            busy_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            step_r  <= step_s;
            level_r <= level_nxt_s;
            done_r  <= done_s;
            busy_r  <= (state_s != ST_IDLE);
        end
    end

    assign level_cur_s = level_r;
    assign busy_cur_s  = busy_r;
`else
    // Without the fade FSM a start request is simply acknowledged one cycle later
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            done_r <= 1'b0;
        end else begin
            done_r <= bus.fade_start;
        end
    end

    assign level_cur_s = LVL_MAX;
    assign busy_cur_s  = 1'b0;
`endif

    // Palette storage; reset loads a grey ramp
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 16; i++) begin
                pal_r[i] <= {3{8'(i * 17)}};
            end
        end else if (bus.pal_we) begin
            pal_r[bus.pal_waddr] <= bus.pal_wdata;
        end
    end

    // S0/S1: align blank with the late colour index and read the palette
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            blank_d1_r <= 1'b0;
            blank_d2_r <= 1'b0;
            pix_r      <= 24'd0;
        end else begin
            blank_d1_r <= bus.blank_n;
            blank_d2_r <= blank_d1_r;
            pix_r      <= pal_r[bus.color_idx];
        end
    end

    // S2 colour: brightness scaling and blank forcing
    always_comb begin
        rgb_nxt_s = 24'd0;
        if (blank_d2_r) begin
`ifdef VGA_FADE_EN
            rgb_nxt_s = {scale_chan(pix_r[23:16], level_cur_s),
                         scale_chan(pix_r[15:8],  level_cur_s),
                         scale_chan(pix_r[7:0],   level_cur_s)};
`else
            rgb_nxt_s = pix_r;
`endif
        end else begin
            rgb_nxt_s = 24'd0;
        end
    end

    // S2 output register
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            rgb_r <= 24'd0;
        end else begin
            rgb_r <= rgb_nxt_s;
        end
    end

    assign bus.VGA_R      = rgb_r[23:16];
    assign bus.VGA_G      = rgb_r[15:8];
    assign bus.VGA_B      = rgb_r[7:0];
    assign bus.fade_level = level_cur_s;
    assign bus.fade_busy  = busy_cur_s;
    assign bus.fade_done  = done_r;

endmodule
